// File: rtl/bomb_fuse_scheduler.sv
// rtl/bomb_fuse_scheduler.sv - four-slot bomb fuse timer with round-robin explosion output
module bomb_fuse_scheduler #(
    parameter int TICK_DIV   = 100000000,
    parameter int FUSE_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm_req,
    input  logic [7:0] arm_pos,
    output logic       arm_ack,
    output logic       arm_full,
    input  logic       pause,
    output logic       explode_valid,
    output logic [7:0] explode_pos,
    output logic [1:0] explode_slot,
    input  logic       explode_ready,
    output logic [3:0] active,
    output logic       tick
);

    localparam int             CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  PRE_MAX   = CW'(TICK_DIV - 1);
    localparam logic [3:0]     FUSE_INIT = 4'(FUSE_TICKS);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BURNING = 2'd1,
        EXPIRED = 2'd2
    } slot_state_t;

    // Registered state
    logic [CW-1:0] pre_cnt;
    slot_state_t   slot_st  [4];
    logic [7:0]    slot_pos [4];
    logic [3:0]    slot_rem [4];
    logic [1:0]    rr_last;

    // Next-state values
    logic [CW-1:0] pre_cnt_nxt;
    logic          tick_nxt;
    slot_state_t   slot_st_nxt  [4];
    logic [7:0]    slot_pos_nxt [4];
    logic [3:0]    slot_rem_nxt [4];
    logic [1:0]    rr_last_nxt;
    logic          valid_nxt;
    logic [7:0]    epos_nxt;
    logic [1:0]    eslot_nxt;
    logic [3:0]    active_nxt;

    // Selection helpers
    logic          arm_hit;
    logic [1:0]    arm_idx;
    logic          arm_fire;
    logic          exp_hit;
    logic [1:0]    exp_idx;
    logic [1:0]    cand;
    logic          out_load;

    // Arm is accepted whenever the registered full flag is clear.
    assign arm_ack  = arm_req & ~arm_full;
    assign arm_fire = arm_ack & arm_hit;
    assign out_load = ~explode_valid | explode_ready;

    // Lowest-index FREE slot receives the next armed bomb.
    always_comb begin
        arm_hit = 1'b0;
        arm_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (slot_st[i] == FREE) begin
                arm_hit = 1'b1;
                arm_idx = 2'(i);
            end
        end
    end

    // Round-robin search for an EXPIRED slot, starting one past the last served.
    always_comb begin
        exp_hit = 1'b0;
        exp_idx = rr_last;
        cand    = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = rr_last + 2'(k);
            if (slot_st[cand] == EXPIRED) begin
                exp_hit = 1'b1;
                exp_idx = cand;
            end
        end
    end

    // Tick prescaler: holds while paused, strobes tick for one cycle on wrap.
    always_comb begin
        pre_cnt_nxt = pre_cnt;
        tick_nxt    = 1'b0;
        if (!pause) begin
            if (pre_cnt == PRE_MAX) begin
                pre_cnt_nxt = '0;
                tick_nxt    = 1'b1;
            end else begin
                pre_cnt_nxt = pre_cnt + 1'b1;
            end
        end
    end

    // Slot countdown, output register loading and arming.
    always_comb begin
        slot_st_nxt  = slot_st;
        slot_pos_nxt = slot_pos;
        slot_rem_nxt = slot_rem;
        rr_last_nxt  = rr_last;
        valid_nxt    = explode_valid;
        epos_nxt     = explode_pos;
        eslot_nxt    = explode_slot;
        active_nxt   = 4'd0;

        // A slot being armed is FREE this cycle, so the tick never touches it.
        for (int i = 0; i < 4; i++) begin
            if (tick && slot_st[i] == BURNING) begin
                if (slot_rem[i] == 4'd1) begin
                    slot_st_nxt[i]  = EXPIRED;
                    slot_rem_nxt[i] = 4'd0;
                end else begin
                    slot_rem_nxt[i] = slot_rem[i] - 4'd1;
                end
            end
        end

        if (out_load) begin
            if (exp_hit) begin
                valid_nxt            = 1'b1;
                epos_nxt             = slot_pos[exp_idx];
                eslot_nxt            = exp_idx;
                rr_last_nxt          = exp_idx;
                slot_st_nxt[exp_idx] = FREE;
            end else begin
                valid_nxt = 1'b0;
            end
        end

        if (arm_fire) begin
            slot_st_nxt[arm_idx]  = BURNING;
            slot_pos_nxt[arm_idx] = arm_pos;
            slot_rem_nxt[arm_idx] = FUSE_INIT;
        end

        for (int i = 0; i < 4; i++) begin
            active_nxt[i] = (slot_st_nxt[i] != FREE);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt       <= '0;
            tick          <= 1'b0;
            rr_last       <= 2'd3;
            explode_valid <= 1'b0;
            explode_pos   <= 8'd0;
            explode_slot  <= 2'd0;
            active        <= 4'd0;
            arm_full      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot_st[i]  <= FREE;
                slot_pos[i] <= 8'd0;
                slot_rem[i] <= 4'd0;
            end
        end else begin
            pre_cnt       <= pre_cnt_nxt;
            tick          <= tick_nxt;
            rr_last       <= rr_last_nxt;
            explode_valid <= valid_nxt;
            explode_pos   <= epos_nxt;
            explode_slot  <= eslot_nxt;
            active        <= active_nxt;
            arm_full      <= &active_nxt;
            slot_st       <= slot_st_nxt;
            slot_pos      <= slot_pos_nxt;
            slot_rem      <= slot_rem_nxt;
        end
    end

endmodule

// File: tb/tb_bomb_fuse_scheduler.sv
// tb/tb_bomb_fuse_scheduler.sv - self-checking bench for bomb_fuse_scheduler
module tb_bomb_fuse_scheduler;

    localparam int TD = 4;
    localparam int FT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       arm_req = 1'b0;
    logic [7:0] arm_pos = 8'd0;
    logic       arm_ack;
    logic       arm_full;
    logic       pause = 1'b0;
    logic       explode_valid;
    logic [7:0] explode_pos;
    logic [1:0] explode_slot;
    logic       explode_ready = 1'b0;
    logic [3:0] active;
    logic       tick;

    bomb_fuse_scheduler #(.TICK_DIV(TD), .FUSE_TICKS(FT)) dut (
        .clk(clk), .rst(rst),
        .arm_req(arm_req), .arm_pos(arm_pos), .arm_ack(arm_ack), .arm_full(arm_full),
        .pause(pause),
        .explode_valid(explode_valid), .explode_pos(explode_pos),
        .explode_slot(explode_slot), .explode_ready(explode_ready),
        .active(active), .tick(tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: slot status 0=free 1=burning 2=expired, fuse as tick count.
    int m_st  [4];
    int m_pos [4];
    int m_rem [4];
    int m_cnt;
    bit m_tick;
    bit m_valid;
    int m_epos;
    int m_eslot;
    int m_last;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_st[i] = 0; m_pos[i] = 0; m_rem[i] = 0;
        end
        m_cnt = 0; m_tick = 0; m_valid = 0; m_epos = 0; m_eslot = 0; m_last = 3;
    endfunction

    function automatic bit model_full();
        int used = 0;
        for (int i = 0; i < 4; i++) if (m_st[i] != 0) used++;
        return used == 4;
    endfunction

    function automatic void model_step(bit req, int pos, bit pz, bit rdy);
        int  n_st [4];
        int  n_pos [4];
        int  n_rem [4];
        bit  ack;
        bit  found;
        n_st = m_st; n_pos = m_pos; n_rem = m_rem;
        ack = req && !model_full();
        if (m_tick) begin
            for (int i = 0; i < 4; i++) begin
                if (m_st[i] == 1) begin
                    n_rem[i] = m_rem[i] - 1;
                    if (n_rem[i] == 0) n_st[i] = 2;
                end
            end
        end
        if (!m_valid || rdy) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                int idx = (m_last + k) % 4;
                if (!found && m_st[idx] == 2) begin
                    found = 1;
                    n_st[idx] = 0;
                    m_epos = m_pos[idx];
                    m_eslot = idx;
                    m_last = idx;
                end
            end
            m_valid = found;
        end
        if (ack) begin
            found = 0;
            for (int i = 0; i < 4; i++) begin
                if (!found && m_st[i] == 0) begin
                    found = 1;
                    n_st[i] = 1; n_pos[i] = pos; n_rem[i] = FT;
                end
            end
        end
        if (pz) m_tick = 0;
        else if (m_cnt == TD - 1) begin m_cnt = 0; m_tick = 1; end
        else begin m_cnt++; m_tick = 0; end
        m_st = n_st; m_pos = n_pos; m_rem = n_rem;
    endfunction

    task automatic check_outputs();
        logic [3:0] exp_act;
        for (int i = 0; i < 4; i++) exp_act[i] = (m_st[i] != 0);
        check("active", active, exp_act);
        check("arm_full", arm_full, model_full());
        check("tick", tick, m_tick);
        check("explode_valid", explode_valid, m_valid);
        if (m_valid) begin
            check("explode_pos", explode_pos, m_epos);
            check("explode_slot", explode_slot, m_eslot);
        end
    endtask

    // One clock cycle: drive at the falling edge, check outputs at the next one.
    task automatic cycle(input bit req, input logic [7:0] pos, input bit pz, input bit rdy);
        arm_req = req; arm_pos = pos; pause = pz; explode_ready = rdy;
        #1;
        check("arm_ack", arm_ack, req && !model_full());
        model_step(req, pos, pz, rdy);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b0; arm_req = 1'b0; pause = 1'b0; explode_ready = 1'b0;
        model_reset();
        #1;
        check("rst_valid", explode_valid, 0);
        check("rst_pos", explode_pos, 0);
        check("rst_slot", explode_slot, 0);
        check("rst_active", active, 0);
        check("rst_full", arm_full, 0);
        check("rst_tick", tick, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_until_valid(input bit rdy, input int budget);
        int n = 0;
        while (!explode_valid && n < budget) begin
            cycle(1'b0, 8'h00, 1'b0, rdy);
            n++;
        end
    endtask

    int arm_c;
    int seen;

    initial begin
        @(negedge clk);
        do_reset();

        // Single bomb: valid two cycles after the third tick.
        cycle(1'b1, 8'h2A, 1'b0, 1'b1);
        arm_c = cyc;
        check("single_active", active, 4'b0001);
        run_until_valid(1'b1, 60);
        check("single_lat", cyc - arm_c, 13);
        check("single_pos", explode_pos, 8'h2A);
        check("single_slot", explode_slot, 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("single_active_after", active, 4'b0000);
        check("single_valid_after", explode_valid, 0);

        // Full slots: fifth arm request is refused.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
        check("full_flag", arm_full, 1);
        check("full_active", active, 4'hF);
        arm_req = 1'b1;
        #1;
        check("full_ack", arm_ack, 0);
        cycle(1'b1, 8'h55, 1'b0, 1'b1);
        check("full_active2", active, 4'hF);

        // Simultaneous expiry with backpressure, then drained in slot order.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        run_until_valid(1'b0, 60);
        check("sim_valid", explode_valid, 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("sim_hold_slot", explode_slot, 0);
        check("sim_hold_pos", explode_pos, 8'h10);
        for (int j = 0; j < 4; j++) begin
            check("sim_drain_valid", explode_valid, 1);
            check("sim_drain_slot", explode_slot, j);
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
        end
        check("sim_drained", explode_valid, 0);

        // Pause for 20 cycles after the first tick delays the explosion by 20.
        do_reset();
        cycle(1'b1, 8'h77, 1'b0, 1'b1);
        arm_c = cyc;
        for (int i = 0; i < 8 && !tick; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b1);
            if (tick) seen++;
        end
        check("pause_ticks", seen, 0);
        run_until_valid(1'b1, 80);
        check("pause_lat", cyc - arm_c, 33);

        // Arm in the tick cycle: the strobe does not count toward this bomb.
        do_reset();
        for (int i = 0; i < 8 && !tick; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("coin_tick", tick, 1);
        cycle(1'b1, 8'h5C, 1'b0, 1'b1);
        arm_c = cyc;
        run_until_valid(1'b1, 60);
        check("coin_lat", cyc - arm_c, 13);
        check("coin_pos", explode_pos, 8'h5C);

        // Reset mid-operation drops the pending record and burning fuses.
        do_reset();
        cycle(1'b1, 8'h01, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'h02, 1'b0, 1'b0);
        cycle(1'b1, 8'h03, 1'b0, 1'b0);
        run_until_valid(1'b0, 60);
        check("midrst_valid", explode_valid, 1);
        check("midrst_active", active, 4'b0110);
        do_reset();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1);
            if (explode_valid) seen++;
        end
        check("midrst_no_explode", seen, 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset();
            else cycle($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 19) == 0,
                       $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
